// File: rtl/dff_en.sv
// Parameterised D flip-flop with optional load enable and synchronous active-high reset.
// q is the register output directly; there is no combinational path from any input to q.
module dff_en #(
  parameter bit                USE_EN      = 1'b1,
  parameter int unsigned       WIDTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Capture d when enabled (or always, when the enable is compiled out); otherwise hold.
  always_comb begin
    q_d = q_q;
    if (!USE_EN || en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_dff_en.sv
// Scoreboard bench for dff_en: default, enable-bypass and 8-bit/A5-reset instances.
module tb_dff_en;

  logic       clk;
  logic       rst_def, rst_byp, rst_w8;
  logic       d_def, d_byp;
  logic [7:0] d_w8;
  logic       en_def, en_byp, en_w8;
  logic       q_def, q_byp;
  logic [7:0] q_w8;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string       tag;
    int unsigned inst;
    logic [7:0]  exp;
  } exp_t;

  exp_t sb[$];

  dff_en u_def (
    .clk (clk),
    .rst (rst_def),
    .d   (d_def),
    .en  (en_def),
    .q   (q_def)
  );

  dff_en #(.USE_EN(1'b0), .WIDTH(1), .RESET_VALUE(1'b0)) u_byp (
    .clk (clk),
    .rst (rst_byp),
    .d   (d_byp),
    .en  (en_byp),
    .q   (q_byp)
  );

  dff_en #(.USE_EN(1'b1), .WIDTH(8), .RESET_VALUE(8'hA5)) u_w8 (
    .clk (clk),
    .rst (rst_w8),
    .d   (d_w8),
    .en  (en_w8),
    .q   (q_w8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(input string tag, input int unsigned inst, input logic [7:0] exp);
    exp_t e;
    e.tag  = tag;
    e.inst = inst;
    e.exp  = exp;
    sb.push_back(e);
  endfunction

  // Pop every pending expectation and compare against the matching instance output.
  task automatic check_pending();
    exp_t       e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.inst)
        0:       obs = {7'b0, q_def};
        1:       obs = {7'b0, q_byp};
        default: obs = q_w8;
      endcase
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One rising edge, then compare at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_pending();
  endtask

  logic       m_def, m_byp;
  logic [7:0] m_w8;

  initial begin
    rst_def = 1'b0; rst_byp = 1'b0; rst_w8 = 1'b0;
    d_def = 1'b0; d_byp = 1'b0; d_w8 = 8'h00;
    en_def = 1'b0; en_byp = 1'b0; en_w8 = 1'b0;
    @(negedge clk);

    // Reset
    rst_def = 1'b1; en_def = 1'b0; d_def = 1'b0;
    rst_byp = 1'b1; en_byp = 1'b0; d_byp = 1'b0;
    rst_w8  = 1'b1; en_w8  = 1'b0; d_w8  = 8'h00;
    push("reset_def", 0, 8'h00);
    push("reset_byp", 1, 8'h00);
    push("reset_w8",  2, 8'hA5);
    cycle();

    // Enabled capture / bypass follow
    rst_def = 1'b0; en_def = 1'b1; d_def = 1'b1;
    rst_byp = 1'b0; d_byp = 1'b1;
    rst_w8  = 1'b0; en_w8 = 1'b1; d_w8 = 8'h3C;
    push("cap1_def", 0, 8'h01);
    push("byp1",     1, 8'h01);
    push("cap_w8",   2, 8'h3C);
    cycle();

    d_def = 1'b0;
    d_byp = 1'b0;
    en_w8 = 1'b0; d_w8 = 8'hFF;
    push("cap0_def", 0, 8'h00);
    push("byp0",     1, 8'h00);
    push("hold_w8",  2, 8'h3C);
    cycle();

    // Hold for two edges
    en_def = 1'b0; d_def = 1'b1;
    d_byp = 1'b1;
    push("hold1_def", 0, 8'h00);
    push("byp1b",     1, 8'h01);
    push("hold2_w8",  2, 8'h3C);
    cycle();

    d_byp = 1'b0;
    push("hold2_def", 0, 8'h00);
    push("byp0b",     1, 8'h00);
    push("hold3_w8",  2, 8'h3C);
    cycle();

    en_def = 1'b1; d_def = 1'b1;
    d_byp = 1'b1;
    en_w8 = 1'b1; d_w8 = 8'h5A;
    push("cap2_def", 0, 8'h01);
    push("byp1c",    1, 8'h01);
    push("cap2_w8",  2, 8'h5A);
    cycle();

    // Reset priority over enable; q unchanged until the edge
    rst_def = 1'b1; en_def = 1'b1; d_def = 1'b1;
    rst_byp = 1'b1; d_byp = 1'b1;
    rst_w8  = 1'b1; en_w8 = 1'b1; d_w8 = 8'hFF;
    #1;
    push("pre_rst_def", 0, 8'h01);
    push("pre_rst_w8",  2, 8'h5A);
    check_pending();
    push("rst_prio_def", 0, 8'h00);
    push("rst_prio_byp", 1, 8'h00);
    push("rst_prio_w8",  2, 8'hA5);
    cycle();

    rst_def = 1'b0; en_def = 1'b1; d_def = 1'b1;
    rst_byp = 1'b0; d_byp = 1'b0;
    rst_w8  = 1'b0; en_w8 = 1'b1; d_w8 = 8'hC3;
    push("resume_def", 0, 8'h01);
    push("resume_byp", 1, 8'h00);
    push("resume_w8",  2, 8'hC3);
    cycle();

    // Reset while holding
    rst_def = 1'b1; en_def = 1'b0;
    d_byp = 1'b1; en_byp = 1'b1;
    rst_w8 = 1'b1; en_w8 = 1'b0;
    push("rst_hold_def", 0, 8'h00);
    push("byp_en_ign",   1, 8'h01);
    push("rst_hold_w8",  2, 8'hA5);
    cycle();

    // Enable glitch between edges must not capture
    rst_def = 1'b0; en_def = 1'b0; d_def = 1'b1;
    rst_w8 = 1'b0; en_w8 = 1'b0; d_w8 = 8'h00;
    d_byp = 1'b0; en_byp = 1'b0;
    #1 en_def = 1'b1; en_w8 = 1'b1;
    #1 en_def = 1'b0; en_w8 = 1'b0;
    push("glitch_def", 0, 8'h00);
    push("byp0c",      1, 8'h00);
    push("glitch_w8",  2, 8'hA5);
    cycle();

    // Randomised traffic against a behavioural model
    m_def = 1'b0; m_byp = 1'b0; m_w8 = 8'hA5;
    for (int i = 0; i < 40; i++) begin
      rst_def = ($urandom_range(0, 7) == 0);
      rst_byp = ($urandom_range(0, 7) == 0);
      rst_w8  = ($urandom_range(0, 7) == 0);
      en_def  = 1'($urandom_range(0, 1));
      en_byp  = 1'($urandom_range(0, 1));
      en_w8   = 1'($urandom_range(0, 1));
      d_def   = 1'($urandom_range(0, 1));
      d_byp   = 1'($urandom_range(0, 1));
      d_w8    = 8'($urandom_range(0, 255));
      m_def = rst_def ? 1'b0  : (en_def ? d_def : m_def);
      m_byp = rst_byp ? 1'b0  : d_byp;
      m_w8  = rst_w8  ? 8'hA5 : (en_w8 ? d_w8 : m_w8);
      push("rand_def", 0, {7'b0, m_def});
      push("rand_byp", 1, {7'b0, m_byp});
      push("rand_w8",  2, m_w8);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
